// File: rtl/logic_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_pkg;
  localparam int LOGIC_OP_W = 2;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } logic_op_t;
endpackage

// File: rtl/logic_core.sv
// Combinational bitwise op with zero and parity status of the result.
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic_op_t        op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             parity_o
);
  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_AND:  result_o = x_i & y_i;
      OP_OR:   result_o = x_i | y_i;
      OP_XOR:  result_o = x_i ^ y_i;
      OP_NOR:  result_o = ~(x_i | y_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o   = ~|result_o;
  assign parity_o = ^result_o;
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic pipeline: S1 holds operands, S2 holds
// the result and flags. Ready propagates backwards combinationally.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [LOGIC_OP_W-1:0] OP,
  input  logic [WIDTH-1:0]      X,
  input  logic [WIDTH-1:0]      Y,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [WIDTH-1:0]      OUT,
  output logic                  ZERO,
  output logic                  PARITY
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic_op_t        op_q;
  logic [WIDTH-1:0] out_q, res_d;
  logic             zero_q, parity_q, zero_d, parity_d;
  logic             s1_ready, s2_ready, in_xfer, adv;

  assign s2_ready = !vld_pipe_q[2] || OUT_READY;
  assign s1_ready = !vld_pipe_q[1] || s2_ready;
  assign in_xfer  = IN_VALID && s1_ready;
  assign adv      = vld_pipe_q[1] && s2_ready;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (op_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .result_o(res_d),
    .zero_o  (zero_d),
    .parity_o(parity_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= OP_AND;
      out_q      <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
    end else begin
      if (in_xfer) begin
        x_q  <= X;
        y_q  <= Y;
        op_q <= logic_op_t'(OP);
      end
      if (adv) begin
        out_q    <= res_d;
        zero_q   <= zero_d;
        parity_q <= parity_d;
      end
      // A stage stays full if it refills this cycle or could not drain.
      vld_pipe_q[1] <= in_xfer || (vld_pipe_q[1] && !adv);
      vld_pipe_q[2] <= adv || (vld_pipe_q[2] && !OUT_READY);
    end
  end

  assign IN_READY  = s1_ready;
  assign OUT_VALID = vld_pipe_q[2];
  assign OUT       = out_q;
  assign ZERO      = zero_q;
  assign PARITY    = parity_q;
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Two-stage pipelined bitwise logic unit.
- Consumes operand pairs that the combinational gate cells (AND/OR/XOR) otherwise see directly, and produces a registered result with status flags for the datapath writeback stage.
- Valid/ready handshake on both sides.
- Throughput of one operation per cycle; stalls cleanly under backpressure without dropping or duplicating data.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 64).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  the upstream stage presents X, Y and OP.
- IN_READY  output  1  the block accepts the input this cycle.
- OP  input  2  operation select: 0 = AND, 1 = OR, 2 = XOR, 3 = NOR.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- OUT_VALID  output  1  OUT, ZERO and PARITY hold a valid result.
- OUT_READY  input  1  the downstream stage accepts the result.
- OUT  output  WIDTH  registered result.
- ZERO  output  1  set when OUT is all zeros.
- PARITY  output  1  XOR-reduction of OUT (1 = odd number of ones).

Behaviour:
- Reset:
  - Asynchronous assertion of RST clears s1_valid and s2_valid immediately.
  - OUT is 0, ZERO is 1, PARITY is 0, OUT_VALID is 0.
  - IN_READY is 1 once RST is low.
  - Stage-1 operand registers reset to 0.
- Reset mid-operation: all in-flight operations are discarded and none are emitted after RST is released.
- Stage 1 (S1): registers X, Y, OP and s1_valid.
- Stage 2 (S2): registers OUT = f(OP, X, Y), ZERO, PARITY and s2_valid.
- Ready chain (combinational, no input-to-output combinational path other than this):
  - s2_ready = !s2_valid || OUT_READY
  - s1_ready = !s1_valid || s2_ready
  - IN_READY = s1_ready
- Input transfer: occurs when IN_VALID && IN_READY at the clock edge. S1 captures the operands and sets s1_valid.
- S1 to S2 transfer: occurs when s1_valid && s2_ready.
  - S2 captures the result and flags and sets s2_valid.
  - S1 clears s1_valid unless a new input transfers in the same cycle.
- Output transfer: occurs when OUT_VALID && OUT_READY. s2_valid clears unless S1 advances in the same cycle.
- Latency: an accepted input appears on OUT_VALID exactly 2 cycles later when OUT_READY is held high.
- Stall:
  - While OUT_READY = 0 and both stages are full, IN_READY = 0.
  - OUT, ZERO and PARITY hold stable; S1 holds stable.
  - Maximum occupancy is 2 operations.
- Simultaneous accept, advance and emit in one cycle is legal. The pipeline streams 1 op per cycle with no bubble.
- OUT_VALID = 0: OUT and the flags hold their last value. The downstream stage must ignore them.
- OP is fully decoded; there are no illegal codes.
- Width: all logic is bitwise on WIDTH bits. There is no carry or sign, and no truncation or extension occurs.
- X, Y and OP may change freely while IN_VALID = 0 or IN_READY = 0; only the values at the transfer edge matter.

Decomposition:
- Package logic_pkg holds:
  - typedef enum logic [1:0] logic_op_t {OP_AND = 0, OP_OR = 1, OP_XOR = 2, OP_NOR = 3}.
  - The constant LOGIC_OP_W = 2.
- One combinational sub-module, logic_core, maps (op, x, y) to (result, zero, parity). It is instantiated in S2's input path.
- Pipeline registers and handshake logic live in logic_unit_pipe.

Test Plan:
- Reset check: assert RST mid-stream with 2 ops in flight, then release. Required: OUT_VALID = 0, OUT = 0x00, ZERO = 1, PARITY = 0, IN_READY = 1, and no stale result ever appears.
- Opcode sweep: X = 0xF0, Y = 0x3C, OUT_READY = 1, OP = 0, 1, 2, 3 on consecutive cycles. Required OUT values 2 cycles later, one per cycle:
  - 0x30 (PARITY 0)
  - 0xFC (PARITY 0)
  - 0xCC (PARITY 0)
  - 0x03 (PARITY 0)
  - ZERO = 0 throughout.
- Zero flag: OP = AND, X = 0xAA, Y = 0x55. Required: OUT = 0x00, ZERO = 1, PARITY = 0. Then OP = OR, X = 0x01, Y = 0x00. Required: OUT = 0x01, ZERO = 0, PARITY = 1.
- Backpressure, part 1: stream 4 ops with OUT_READY = 0 from cycle 2. Required: IN_READY drops after 2 accepts, OUT holds the first result stable.
- Backpressure, part 2: release OUT_READY. Required: all 4 results emerge in order, with no loss or duplication.
- Random streaming: 1000 ops with random IN_VALID and OUT_READY (50% each). Required:
  - A scoreboard matches every result in order.
  - Occupancy never exceeds 2.
  - OUT is stable while OUT_VALID && !OUT_READY.
